// File: rtl/ariane_pkg.sv
// Shared issue-stage types: scoreboard sizing, exception record and scoreboard entry layout.
package ariane_pkg;

   localparam int unsigned NR_SB_ENTRIES = 4;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
   localparam int unsigned NR_WB_PORTS   = 3;

   typedef enum logic [2:0] {
      FuNone,
      FuAlu,
      FuLsu,
      FuMult,
      FuCsr,
      FuBranch
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      fu_t                      fu;
      logic [6:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      exception                 ex;
   } scoreboard_entry;

endpackage

// File: rtl/sb_fwd_lookup.sv
// Operand forwarding search: finds the youngest in-flight entry that writes rs_i.
module sb_fwd_lookup
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
   localparam int unsigned IdBits = $clog2(NR_ENTRIES)
) (
   input  scoreboard_entry [NR_ENTRIES-1:0] entries_i,
   input  logic [NR_ENTRIES-1:0]            in_flight_i,
   input  logic [IdBits-1:0]                tail_i,
   input  logic [4:0]                       rs_i,
   output logic                             hit_o,
   output logic                             valid_o,
   output logic [63:0]                      result_o
);

   logic [IdBits-1:0] idx;

   // Walk oldest to youngest so the youngest match is the last one written.
   always_comb begin
      hit_o    = 1'b0;
      valid_o  = 1'b0;
      result_o = '0;
      idx      = '0;
      for (int k = int'(NR_ENTRIES); k >= 1; k--) begin
         idx = tail_i - IdBits'(k);
         if (in_flight_i[idx] && (entries_i[idx].rd == rs_i) && (rs_i != 5'd0)) begin
            hit_o    = 1'b1;
            valid_o  = entries_i[idx].valid;
            result_o = entries_i[idx].result;
         end
      end
   end

endmodule

// File: rtl/scoreboard.sv
// In-order-commit, out-of-order-writeback scoreboard with operand forwarding.
module scoreboard
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
   parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS,
   localparam int unsigned IdBits = $clog2(NR_ENTRIES)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  scoreboard_entry                     issue_instr_i,
   input  logic                                issue_valid_i,
   output logic                                issue_ready_o,
   output logic [IdBits-1:0]                   issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]              wb_valid_i,
   input  logic [NR_WB_PORTS-1:0][IdBits-1:0]  wb_trans_id_i,
   input  logic [NR_WB_PORTS-1:0][63:0]        wb_data_i,
   input  exception [NR_WB_PORTS-1:0]          wb_ex_i,
   output scoreboard_entry                     commit_instr_o,
   output logic                                commit_valid_o,
   input  logic                                commit_ack_i,
   input  logic [4:0]                          rs1_i,
   input  logic [4:0]                          rs2_i,
   output logic                                rs1_hit_o,
   output logic                                rs2_hit_o,
   output logic                                rs1_valid_o,
   output logic                                rs2_valid_o,
   output logic [63:0]                         rs1_o,
   output logic [63:0]                         rs2_o
);

   scoreboard_entry [NR_ENTRIES-1:0] mem_q, mem_d;
   logic [NR_ENTRIES-1:0]            in_flight_q, in_flight_d;
   logic [IdBits-1:0]                head_q, head_d, tail_q, tail_d;
   logic [IdBits:0]                  count_q, count_d;
   logic                             issue_fire, commit_fire;
   logic                             wb_conflict;

   assign issue_ready_o    = (count_q != (IdBits+1)'(NR_ENTRIES));
   assign issue_trans_id_o = tail_q;
   assign commit_instr_o   = mem_q[head_q];
   assign commit_valid_o   = in_flight_q[head_q] & mem_q[head_q].valid;
   assign issue_fire       = issue_valid_i & issue_ready_o;
   assign commit_fire      = commit_ack_i & commit_valid_o;

   always_comb begin
      mem_d       = mem_q;
      in_flight_d = in_flight_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;

      if (issue_fire) begin
         mem_d[tail_q]          = issue_instr_i;
         mem_d[tail_q].trans_id = TRANS_ID_BITS'(tail_q);
         // Fetch exceptions carry no result and commit without execution.
         mem_d[tail_q].valid    = issue_instr_i.ex.valid;
         in_flight_d[tail_q]    = 1'b1;
         tail_d                 = tail_q + IdBits'(1);
      end

      // Highest port first so the lowest index wins a (forbidden) collision.
      for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
         if (wb_valid_i[p] && in_flight_q[wb_trans_id_i[p]]) begin
            mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
            mem_d[wb_trans_id_i[p]].valid  = 1'b1;
            if (wb_ex_i[p].valid) begin
               mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
            end
         end
      end

      if (commit_fire) begin
         in_flight_d[head_q] = 1'b0;
         head_d              = head_q + IdBits'(1);
      end

      case ({issue_fire, commit_fire})
         2'b10:   count_d = count_q + (IdBits+1)'(1);
         2'b01:   count_d = count_q - (IdBits+1)'(1);
         default: count_d = count_q;
      endcase

      if (flush_i) begin
         in_flight_d = '0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q       <= '0;
         in_flight_q <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
      end else begin
         mem_q       <= mem_d;
         in_flight_q <= in_flight_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
      end
   end

   sb_fwd_lookup #(
      .NR_ENTRIES (NR_ENTRIES)
   ) u_fwd_rs1 (
      .entries_i   (mem_q),
      .in_flight_i (in_flight_q),
      .tail_i      (tail_q),
      .rs_i        (rs1_i),
      .hit_o       (rs1_hit_o),
      .valid_o     (rs1_valid_o),
      .result_o    (rs1_o)
   );

   sb_fwd_lookup #(
      .NR_ENTRIES (NR_ENTRIES)
   ) u_fwd_rs2 (
      .entries_i   (mem_q),
      .in_flight_i (in_flight_q),
      .tail_i      (tail_q),
      .rs_i        (rs2_i),
      .hit_o       (rs2_hit_o),
      .valid_o     (rs2_valid_o),
      .result_o    (rs2_o)
   );

   always_comb begin
      wb_conflict = 1'b0;
      for (int i = 0; i < int'(NR_WB_PORTS); i++) begin
         for (int j = i + 1; j < int'(NR_WB_PORTS); j++) begin
            if (wb_valid_i[i] && wb_valid_i[j] && (wb_trans_id_i[i] == wb_trans_id_i[j])) begin
               wb_conflict = 1'b1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   wb_unique_target : assert property (@(posedge clk_i) disable iff (!rst_ni) !wb_conflict)
      else $error("two writeback ports target the same trans_id");
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: issue, out-of-order writeback, forwarding, wrap, flush.
module tb_scoreboard;
   import ariane_pkg::*;

   logic                  clk_i;
   logic                  rst_ni;
   logic                  flush_i;
   scoreboard_entry       issue_instr;
   logic                  issue_valid;
   logic                  issue_ready;
   logic [1:0]            issue_trans_id;
   logic [2:0]            wb_valid;
   logic [2:0][1:0]       wb_trans_id;
   logic [2:0][63:0]      wb_data;
   exception [2:0]        wb_ex;
   scoreboard_entry       commit_instr;
   logic                  commit_valid;
   logic                  commit_ack;
   logic [4:0]            rs1, rs2;
   logic                  rs1_hit, rs2_hit, rs1_valid, rs2_valid;
   logic [63:0]           rs1_data, rs2_data;

   int checks   = 0;
   int failures = 0;

   scoreboard #(
      .NR_ENTRIES  (4),
      .NR_WB_PORTS (3)
   ) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .issue_instr_i    (issue_instr),
      .issue_valid_i    (issue_valid),
      .issue_ready_o    (issue_ready),
      .issue_trans_id_o (issue_trans_id),
      .wb_valid_i       (wb_valid),
      .wb_trans_id_i    (wb_trans_id),
      .wb_data_i        (wb_data),
      .wb_ex_i          (wb_ex),
      .commit_instr_o   (commit_instr),
      .commit_valid_o   (commit_valid),
      .commit_ack_i     (commit_ack),
      .rs1_i            (rs1),
      .rs2_i            (rs2),
      .rs1_hit_o        (rs1_hit),
      .rs2_hit_o        (rs2_hit),
      .rs1_valid_o      (rs1_valid),
      .rs2_valid_o      (rs2_valid),
      .rs1_o            (rs1_data),
      .rs2_o            (rs2_data)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic scoreboard_entry mk_entry(input logic [4:0] rd, input logic exv);
      scoreboard_entry e;
      e          = '0;
      e.rd       = rd;
      e.ex.valid = exv;
      return e;
   endfunction

   task automatic idle();
      flush_i     = 1'b0;
      issue_instr = '0;
      issue_valid = 1'b0;
      wb_valid    = '0;
      wb_trans_id = '0;
      wb_data     = '0;
      wb_ex       = '0;
      commit_ack  = 1'b0;
   endtask

   // Inputs change at the falling edge; outputs are sampled 1 time unit later.
   task automatic cycle();
      @(negedge clk_i);
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
   endtask

   initial begin
      idle();
      rs1    = 5'd1;
      rs2    = 5'd2;
      rst_ni = 1'b0;
      repeat (2) cycle();
      rst_ni = 1'b1;
      #1;
      check_eq("rst_ready", issue_ready, 1);
      check_eq("rst_trans_id", issue_trans_id, 0);
      check_eq("rst_commit_valid", commit_valid, 0);
      check_eq("rst_rs1_hit", rs1_hit, 0);
      check_eq("rst_rs2_valid", rs2_valid, 0);

      // Fill with rd=1..4.
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1;
         issue_instr = mk_entry(5'(i + 1), 1'b0);
         #1;
         check_eq("fill_id", issue_trans_id, 64'(i));
         cycle();
      end
      issue_valid = 1'b0;
      rs1 = 5'd3;
      #1;
      check_eq("full_ready", issue_ready, 0);
      check_eq("full_commit_valid", commit_valid, 0);
      check_eq("fill_rs1_hit", rs1_hit, 1);
      check_eq("fill_rs1_valid", rs1_valid, 0);

      // Out-of-order writeback, in-order commit.
      wb_valid = 3'b100; wb_trans_id[2] = 2'd1; wb_data[2] = 64'hAA;
      cycle();
      wb_valid = '0;
      #1;
      check_eq("ooo_head_waits", commit_valid, 0);
      wb_valid = 3'b001; wb_trans_id[0] = 2'd0; wb_data[0] = 64'h55;
      cycle();
      wb_valid = '0;
      #1;
      check_eq("ooo_cv0", commit_valid, 1);
      check_eq("ooo_res0", commit_instr.result, 64'h55);
      check_eq("ooo_id0", commit_instr.trans_id, 0);
      commit_ack = 1'b1;
      cycle();
      #1;
      check_eq("ooo_cv1", commit_valid, 1);
      check_eq("ooo_res1", commit_instr.result, 64'hAA);
      check_eq("ooo_id1", commit_instr.trans_id, 1);
      cycle();
      commit_ack = 1'b0;
      #1;
      check_eq("ooo_cv2", commit_valid, 0);
      check_eq("ooo_ready", issue_ready, 1);
      do_flush();

      // Forwarding: two producers of x5, youngest decides.
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd5, 1'b0);
      repeat (2) cycle();
      issue_valid = 1'b0;
      wb_valid = 3'b010; wb_trans_id[1] = 2'd0; wb_data[1] = 64'h11;
      cycle();
      wb_valid = '0;
      rs1 = 5'd5;
      #1;
      check_eq("fwd_hit", rs1_hit, 1);
      check_eq("fwd_valid_old", rs1_valid, 0);
      wb_valid = 3'b001; wb_trans_id[0] = 2'd1; wb_data[0] = 64'h77;
      #1;
      check_eq("fwd_no_bypass", rs1_valid, 0);
      cycle();
      wb_valid = '0;
      #1;
      check_eq("fwd_valid_young", rs1_valid, 1);
      check_eq("fwd_data", rs1_data, 64'h77);
      rs2 = 5'd5;
      rs1 = 5'd0;
      #1;
      check_eq("fwd_x0", rs1_hit, 0);
      check_eq("fwd_rs2_data", rs2_data, 64'h77);
      do_flush();

      // Full with a concurrent commit: no bypass, issue lands next cycle on old head.
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd6, 1'b1);
      repeat (4) cycle();
      commit_ack = 1'b1;
      #1;
      check_eq("full_ack_ready", issue_ready, 0);
      check_eq("full_ack_cv", commit_valid, 1);
      cycle();
      commit_ack = 1'b0;
      #1;
      check_eq("after_ack_ready", issue_ready, 1);
      check_eq("after_ack_id", issue_trans_id, 0);
      check_eq("after_ack_head", commit_instr.trans_id, 1);
      cycle();
      issue_valid = 1'b0;
      #1;
      check_eq("refull_ready", issue_ready, 0);
      do_flush();

      // Wrap: ten issue/commit pairs.
      for (int i = 0; i < 10; i++) begin
         issue_valid = 1'b1;
         issue_instr = mk_entry(5'd6, 1'b1);
         cycle();
         issue_valid = 1'b0;
         commit_ack  = 1'b1;
         #1;
         check_eq("wrap_commit_id", commit_instr.trans_id, 64'(i % 4));
         cycle();
         commit_ack = 1'b0;
      end
      #1;
      check_eq("wrap_tail", issue_trans_id, 2);
      check_eq("wrap_empty", commit_valid, 0);
      // Simultaneous issue and commit keeps count, advances both pointers.
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd6, 1'b1);
      cycle();
      commit_ack = 1'b1;
      cycle();
      issue_valid = 1'b0;
      commit_ack  = 1'b0;
      #1;
      check_eq("dual_head", commit_instr.trans_id, 3);
      check_eq("dual_cv", commit_valid, 1);
      check_eq("dual_tail", issue_trans_id, 0);
      do_flush();

      // Exceptions: fetch exception commits directly; FU exception is recorded.
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd7, 1'b1);
      cycle();
      issue_valid = 1'b0;
      #1;
      check_eq("fetch_ex_cv", commit_valid, 1);
      commit_ack = 1'b1;
      cycle();
      commit_ack  = 1'b0;
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd8, 1'b0);
      cycle();
      issue_valid = 1'b0;
      #1;
      check_eq("fu_ex_wait", commit_valid, 0);
      wb_valid = 3'b010; wb_trans_id[1] = 2'd1; wb_data[1] = '0;
      wb_ex[1].valid = 1'b1; wb_ex[1].cause = 64'd5;
      cycle();
      wb_valid = '0;
      wb_ex    = '0;
      #1;
      check_eq("fu_ex_cv", commit_valid, 1);
      check_eq("fu_ex_cause", commit_instr.ex.cause, 5);
      check_eq("fu_ex_valid", commit_instr.ex.valid, 1);
      do_flush();

      // Flush overrides concurrent issue, writeback and ack.
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1;
         issue_instr = mk_entry(5'(8 + i), 1'b0);
         cycle();
      end
      issue_valid = 1'b0;
      wb_valid = 3'b001; wb_trans_id[0] = 2'd0; wb_data[0] = 64'h1;
      cycle();
      wb_valid = '0;
      rs1 = 5'd8;
      rs2 = 5'd9;
      #1;
      check_eq("pre_flush_cv", commit_valid, 1);
      check_eq("pre_flush_hit", rs1_hit, 1);
      flush_i     = 1'b1;
      issue_valid = 1'b1;
      issue_instr = mk_entry(5'd11, 1'b0);
      wb_valid = 3'b001; wb_trans_id[0] = 2'd1; wb_data[0] = 64'h2;
      commit_ack  = 1'b1;
      cycle();
      idle();
      #1;
      check_eq("flush_id", issue_trans_id, 0);
      check_eq("flush_cv", commit_valid, 0);
      check_eq("flush_rs1_hit", rs1_hit, 0);
      check_eq("flush_rs2_hit", rs2_hit, 0);
      check_eq("flush_ready", issue_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
